// File: rtl/pixie_fb_arbiter.sv
// pixie_fb_arbiter
// Shares the single-port 1 KB Pixie framebuffer RAM between the display back end
// (fixed-timing reads, absolute priority) and the CPU/DMA side (req/ack, read/write).
// The RAM has a one-cycle registered read, so each granted access is tagged and the
// tag is carried one cycle to decide who owns ram_rdata when it comes back.
module pixie_fb_arbiter #(
    parameter logic [3:0] MAX_WAIT = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    // display back end
    input  logic       disp_rd_en,
    input  logic [9:0] disp_addr,
    output logic [7:0] disp_data,
    // CPU / DMA side
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    // framebuffer RAM
    output logic       ram_en,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    // status
    output logic       wait_overrun
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    // Owner of ram_rdata in the current cycle (the access granted last cycle)
    tag_t       tag_d, tag_q;
    // Whether the CPU access in flight is a write (no read data to capture)
    logic       owner_we_d, owner_we_q;
    // CPU transaction outstanding: set on grant, cleared the cycle after ack
    logic       busy_d, busy_q;
    logic       cpu_ack_d, cpu_ack_q;
    logic [7:0] cpu_rdata_d, cpu_rdata_q;
    // Last display fetch, shown between fetches
    logic [7:0] disp_hold_d, disp_hold_q;
    logic [3:0] wait_cnt_d, wait_cnt_q;
    logic       wait_overrun_d, wait_overrun_q;

    logic       cpu_grant;
    logic       ram_en_c;
    logic       ram_we_c;
    logic [9:0] ram_addr_c;
    logic [7:0] ram_wdata_c;

    // Grant: display always wins; CPU only when no transaction of its own is in flight
    always_comb begin
        tag_d       = TAG_NONE;
        cpu_grant   = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = cpu_addr;
        ram_wdata_c = cpu_wdata;
        if (disp_rd_en) begin
            tag_d      = TAG_DISP;
            ram_en_c   = 1'b1;
            ram_addr_c = disp_addr;
        end else if (cpu_req && !busy_q) begin
            tag_d      = TAG_CPU;
            cpu_grant  = 1'b1;
            ram_en_c   = 1'b1;
            ram_we_c   = cpu_we;
        end
        // Keep the RAM quiet while the arbiter is being reset
        if (reset) begin
            ram_en_c = 1'b0;
            ram_we_c = 1'b0;
        end
    end

    // Next-state for the return path, CPU handshake and wait monitor
    always_comb begin
        owner_we_d     = cpu_grant & cpu_we;
        disp_hold_d    = disp_hold_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ack_d      = 1'b0;
        busy_d         = busy_q;
        wait_cnt_d     = wait_cnt_q;
        wait_overrun_d = wait_overrun_q;

        if (tag_q == TAG_DISP) begin
            disp_hold_d = ram_rdata;
        end

        if (tag_q == TAG_CPU) begin
            cpu_ack_d = 1'b1;
            if (!owner_we_q) begin
                cpu_rdata_d = ram_rdata;
            end
        end

        // busy stays high through the ack cycle, which blocks a grant there
        if (cpu_grant) begin
            busy_d = 1'b1;
        end else if (cpu_ack_q) begin
            busy_d = 1'b0;
        end

        if (cpu_grant) begin
            wait_cnt_d = 4'd0;
        end else if (cpu_req && !busy_q && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        if (wait_cnt_q > MAX_WAIT) begin
            wait_overrun_d = 1'b1;
        end
    end

    // State registers; reset drops any in-flight tag so no stale ack is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q          <= TAG_NONE;
            owner_we_q     <= 1'b0;
            busy_q         <= 1'b0;
            cpu_ack_q      <= 1'b0;
            cpu_rdata_q    <= 8'h00;
            disp_hold_q    <= 8'h00;
            wait_cnt_q     <= 4'd0;
            wait_overrun_q <= 1'b0;
        end else begin
            tag_q          <= tag_d;
            owner_we_q     <= owner_we_d;
            busy_q         <= busy_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_rdata_q    <= cpu_rdata_d;
            disp_hold_q    <= disp_hold_d;
            wait_cnt_q     <= wait_cnt_d;
            wait_overrun_q <= wait_overrun_d;
        end
    end

    // Display data is passed straight through in the return cycle so it is valid
    // exactly one cycle after the strobe; otherwise the held copy is shown.
    assign disp_data    = (tag_q == TAG_DISP) ? ram_rdata : disp_hold_q;
    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign wait_overrun = wait_overrun_q;
    assign ram_en       = ram_en_c;
    assign ram_we       = ram_we_c;
    assign ram_addr     = ram_addr_c;
    assign ram_wdata    = ram_wdata_c;

endmodule

// File: tb/tb_pixie_fb_arbiter.sv
// Directed bench for pixie_fb_arbiter. Two instances share the stimulus: one with the
// default MAX_WAIT and one with MAX_WAIT = 0, each backed by its own RAM model.
module tb_pixie_fb_arbiter;

    logic       clk;
    logic       reset;
    logic       disp_rd_en;
    logic [9:0] disp_addr;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;

    // backdoor preload of both RAM models
    logic       bd_we;
    logic [9:0] bd_addr;
    logic [7:0] bd_data;

    logic [7:0] a_disp_data, b_disp_data;
    logic       a_cpu_ack, b_cpu_ack;
    logic [7:0] a_cpu_rdata, b_cpu_rdata;
    logic       a_ram_en, b_ram_en;
    logic       a_ram_we, b_ram_we;
    logic [9:0] a_ram_addr, b_ram_addr;
    logic [7:0] a_ram_wdata, b_ram_wdata;
    logic [7:0] a_ram_rdata, b_ram_rdata;
    logic       a_wait_overrun, b_wait_overrun;

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];

    int checks;
    int failures;

    pixie_fb_arbiter dut_a (
        .clk(clk), .reset(reset),
        .disp_rd_en(disp_rd_en), .disp_addr(disp_addr), .disp_data(a_disp_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .wait_overrun(a_wait_overrun)
    );

    pixie_fb_arbiter #(.MAX_WAIT(4'd0)) dut_b (
        .clk(clk), .reset(reset),
        .disp_rd_en(disp_rd_en), .disp_addr(disp_addr), .disp_data(b_disp_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .wait_overrun(b_wait_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model for instance A
    always @(posedge clk) begin
        if (bd_we) begin
            mem_a[bd_addr] <= bd_data;
        end else if (a_ram_en) begin
            if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
            else          a_ram_rdata <= mem_a[a_ram_addr];
        end
    end

    // Synchronous-read RAM model for instance B
    always @(posedge clk) begin
        if (bd_we) begin
            mem_b[bd_addr] <= bd_data;
        end else if (b_ram_en) begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
            else          b_ram_rdata <= mem_b[b_ram_addr];
        end
    end

    // Preload contents used by the bench
    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ 8'h5A ^ {a[9:8], 6'b000000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Lets combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        next_cycle();
        bd_we = 1'b1; bd_addr = a; bd_data = d;
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        int lat;
        int acks;
        logic [7:0] disp_exp;
        logic disp_valid;
        logic strobe_prev;
        logic [9:0] strobe_addr_prev;

        checks = 0; failures = 0;
        reset = 1'b1;
        disp_rd_en = 1'b0; disp_addr = 10'h000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = 8'h00;
        bd_we = 1'b0; bd_addr = 10'h000; bd_data = 8'h00;

        // RAM enable must stay low during reset even with a display strobe
        next_cycle();
        disp_rd_en = 1'b1; disp_addr = 10'h155;
        settle();
        chk("rst_ram_en", a_ram_en, 1'b0);
        chk("rst_ram_we", a_ram_we, 1'b0);
        next_cycle();
        disp_rd_en = 1'b0;

        // Preload while still in reset
        preload(10'h010, pat(10'h010));
        preload(10'h020, pat(10'h020));
        for (int i = 0; i < 32; i++) preload(10'h100 + 10'(i), pat(10'h100 + 10'(i)));
        for (int i = 0; i < 16; i++) preload(10'h200 + 10'(i), pat(10'h200 + 10'(i)));
        preload(10'h155, 8'hA5);
        next_cycle();
        bd_we = 1'b0;

        // 1: idle after reset
        next_cycle();
        reset = 1'b0;
        settle();
        chk("t1_ram_en", a_ram_en, 1'b0);
        chk("t1_cpu_ack", a_cpu_ack, 1'b0);
        chk("t1_disp_data", a_disp_data, 8'h00);
        chk("t1_cpu_rdata", a_cpu_rdata, 8'h00);
        chk("t1_overrun", a_wait_overrun, 1'b0);

        // 2: display fetch of 0x155
        next_cycle();
        disp_rd_en = 1'b1; disp_addr = 10'h155;
        settle();
        chk("t2_ram_en", a_ram_en, 1'b1);
        chk("t2_ram_we", a_ram_we, 1'b0);
        chk("t2_ram_addr", a_ram_addr, 10'h155);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            disp_rd_en = 1'b0;
            settle();
            chk($sformatf("t2_disp_n%0d", k), a_disp_data, 8'hA5);
        end
        chk("t2_b_disp", b_disp_data, 8'hA5);

        // 3: CPU write 0x3C to 0x3FF, then read it back
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h3C;
        settle();
        chk("t3_w_ram_en", a_ram_en, 1'b1);
        chk("t3_w_ram_we", a_ram_we, 1'b1);
        chk("t3_w_ram_addr", a_ram_addr, 10'h3FF);
        chk("t3_w_ram_wdata", a_ram_wdata, 8'h3C);
        chk("t3_w_ack_n", a_cpu_ack, 1'b0);
        next_cycle();
        settle();
        chk("t3_w_n1_ram_en", a_ram_en, 1'b0);
        chk("t3_w_n1_ram_we", a_ram_we, 1'b0);
        chk("t3_w_n1_ack", a_cpu_ack, 1'b0);
        next_cycle();
        settle();
        chk("t3_w_n2_ack", a_cpu_ack, 1'b1);
        chk("t3_w_n2_ram_en", a_ram_en, 1'b0);
        chk("t3_w_rdata_kept", a_cpu_rdata, 8'h00);
        next_cycle();
        cpu_we = 1'b0;
        settle();
        chk("t3_r_ram_en", a_ram_en, 1'b1);
        chk("t3_r_ram_we", a_ram_we, 1'b0);
        chk("t3_r_ram_addr", a_ram_addr, 10'h3FF);
        chk("t3_r_ack_n", a_cpu_ack, 1'b0);
        next_cycle();
        settle();
        chk("t3_r_n1_ack", a_cpu_ack, 1'b0);
        chk("t3_r_disp_hold", a_disp_data, 8'hA5);
        next_cycle();
        settle();
        chk("t3_r_n2_ack", a_cpu_ack, 1'b1);
        chk("t3_r_rdata", a_cpu_rdata, 8'h3C);
        next_cycle();
        cpu_req = 1'b0;
        settle();
        chk("t3_ack_pulse", a_cpu_ack, 1'b0);
        chk("t3_rdata_held", a_cpu_rdata, 8'h3C);
        chk("t3_disp_after_cpu", a_disp_data, 8'hA5);

        // 4: collision of display fetch 0x020 with CPU read 0x010
        next_cycle();
        disp_rd_en = 1'b1; disp_addr = 10'h020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        settle();
        chk("t4_n_ram_addr", a_ram_addr, 10'h020);
        chk("t4_n_ram_en", a_ram_en, 1'b1);
        next_cycle();
        disp_rd_en = 1'b0;
        settle();
        chk("t4_n1_ram_addr", a_ram_addr, 10'h010);
        chk("t4_n1_ram_en", a_ram_en, 1'b1);
        chk("t4_n1_disp", a_disp_data, 8'h7A);
        chk("t4_n1_ack", a_cpu_ack, 1'b0);
        next_cycle();
        settle();
        chk("t4_n2_ack", a_cpu_ack, 1'b0);
        chk("t4_n2_disp_hold", a_disp_data, 8'h7A);
        next_cycle();
        settle();
        chk("t4_n3_ack", a_cpu_ack, 1'b1);
        chk("t4_n3_rdata", a_cpu_rdata, 8'h4A);
        chk("t4_b_rdata", b_cpu_rdata, 8'h4A);
        chk("t4_a_overrun", a_wait_overrun, 1'b0);
        chk("t6_b_overrun", b_wait_overrun, 1'b1);
        next_cycle();
        cpu_req = 1'b0;

        // 5: display strobe every 8 cycles with back-to-back CPU reads
        j = 0; lat = 0; acks = 0;
        disp_exp = 8'h00; disp_valid = 1'b0;
        strobe_prev = 1'b0; strobe_addr_prev = 10'h000;
        for (int t = 0; t < 64; t++) begin
            next_cycle();
            disp_rd_en = ((t % 8) == 0);
            disp_addr  = 10'h200 + 10'(t / 8);
            cpu_req    = 1'b1;
            cpu_we     = 1'b0;
            cpu_addr   = 10'h100 + 10'(j);
            settle();
            if (strobe_prev) begin
                disp_exp   = pat(strobe_addr_prev);
                disp_valid = 1'b1;
            end
            if (disp_valid) chk($sformatf("t5_disp_t%0d", t), a_disp_data, disp_exp);
            lat++;
            if (a_cpu_ack) begin
                chk($sformatf("t5_rdata_j%0d", j), a_cpu_rdata, pat(cpu_addr));
                chk($sformatf("t5_latency_j%0d", j), 32'(lat <= 4), 32'd1);
                acks++;
                j++;
                lat = 0;
            end else if (lat > 5) begin
                chk($sformatf("t5_ack_timeout_j%0d", j), lat, 32'd5);
                lat = 0;
            end
            strobe_prev      = disp_rd_en;
            strobe_addr_prev = disp_addr;
        end
        next_cycle();
        disp_rd_en = 1'b0;
        cpu_req = 1'b0;
        chk("t5_ack_count", 32'(acks >= 14), 32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        settle();
        chk("t5_a_overrun", a_wait_overrun, 1'b0);
        chk("t5_b_overrun_sticky", b_wait_overrun, 1'b1);
        chk("t5_disp_final", a_disp_data, pat(10'h207));

        // 6: reset one cycle after a CPU grant
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h101;
        settle();
        chk("t6_grant_en", a_ram_en, 1'b1);
        chk("t6_grant_addr", a_ram_addr, 10'h101);
        next_cycle();
        cpu_req = 1'b0;
        reset = 1'b1;
        disp_rd_en = 1'b1; disp_addr = 10'h155;
        settle();
        chk("t6_rst_ram_en", a_ram_en, 1'b0);
        chk("t6_rst_ram_we", a_ram_we, 1'b0);
        chk("t6_rst_b_ram_en", b_ram_en, 1'b0);
        next_cycle();
        reset = 1'b0;
        disp_rd_en = 1'b0;
        settle();
        chk("t6_ack_a", a_cpu_ack, 1'b0);
        chk("t6_ack_b", b_cpu_ack, 1'b0);
        chk("t6_rdata", a_cpu_rdata, 8'h00);
        chk("t6_disp", a_disp_data, 8'h00);
        chk("t6_overrun_a", a_wait_overrun, 1'b0);
        chk("t6_overrun_b", b_wait_overrun, 1'b0);
        chk("t6_ram_en", a_ram_en, 1'b0);
        next_cycle();
        settle();
        chk("t6_ack_late", a_cpu_ack, 1'b0);
        chk("t6_disp_late", a_disp_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
